// File: rtl/cbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cbus_arbiter
// Description : Round-robin arbiter that shares one cache-bus master port
//               among NUM_REQ requesters. A grant is held for a whole
//               transaction, single beat or burst, until the final beat.
//               While a requester is granted, its request fields pass to the
//               bus unchanged and the bus responses return only to it.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   ireq_*   (in)         per-requester request fields, packed by index
//   iresp_*  (out)        per-requester response (ready/last/data)
//   oreq_*   (out)        bus-side request of the granted requester
//   oresp_*  (in)         bus-side response
//   busy     (out)        high while a transaction is granted
//   grant_idx(out)        currently / most recently granted requester
//
// Revision    : 1.0  initial release
// ============================================================================
module cbus_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      ireq_valid,
    input  logic [NUM_REQ-1:0]      ireq_is_write,
    input  logic [NUM_REQ*3-1:0]    ireq_size,
    input  logic [NUM_REQ*32-1:0]   ireq_addr,
    input  logic [NUM_REQ*4-1:0]    ireq_strobe,
    input  logic [NUM_REQ*32-1:0]   ireq_data,
    input  logic [NUM_REQ*4-1:0]    ireq_len,
    output logic [NUM_REQ-1:0]      iresp_ready,
    output logic [NUM_REQ-1:0]      iresp_last,
    output logic [NUM_REQ*32-1:0]   iresp_data,
    output logic                    oreq_valid,
    output logic                    oreq_is_write,
    output logic [2:0]              oreq_size,
    output logic [31:0]             oreq_addr,
    output logic [3:0]              oreq_strobe,
    output logic [31:0]             oreq_data,
    output logic [3:0]              oreq_len,
    input  logic                    oresp_ready,
    input  logic                    oresp_last,
    input  logic [31:0]             oresp_data,
    output logic                    busy,
    output logic [IDX_W-1:0]        grant_idx
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_sel;
    logic [IDX_W-1:0]   w_sel_nxt;
    logic [IDX_W-1:0]   r_last_grant;
    logic [IDX_W-1:0]   w_last_grant_nxt;
    logic [IDX_W-1:0]   w_pick;
    logic [31:0]        w_cand;
    logic               w_any_valid;

    // ------------------------------------------------------------------------
    // Round-robin pick: scan last_grant+1, last_grant+2, ... modulo NUM_REQ.
    // The loop runs from the farthest candidate to the nearest so that the
    // nearest valid requester is the final assignment and therefore wins.
    // ------------------------------------------------------------------------
    always_comb begin
        w_pick = '0;
        w_cand = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_cand = 32'((int'(r_last_grant) + i) % NUM_REQ);
            if (ireq_valid[w_cand[IDX_W-1:0]]) begin
                w_pick = w_cand[IDX_W-1:0];
            end
        end
    end

    assign w_any_valid = |ireq_valid;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_sel        <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_sel        <= w_sel_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. Burst length is not counted: the bus-side last beat
    // alone ends the grant.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_sel_nxt        = r_sel;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            ST_IDLE: begin
                if (w_any_valid) begin
                    w_sel_nxt   = w_pick;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (oresp_ready && oresp_last) begin
                    w_last_grant_nxt = r_sel;
                    w_state_nxt      = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Forwarding. Everything is zero in IDLE, so a bus response arriving in
    // IDLE never reaches any requester.
    // ------------------------------------------------------------------------
    always_comb begin
        oreq_valid    = 1'b0;
        oreq_is_write = 1'b0;
        oreq_size     = '0;
        oreq_addr     = '0;
        oreq_strobe   = '0;
        oreq_data     = '0;
        oreq_len      = '0;
        iresp_ready   = '0;
        iresp_last    = '0;
        iresp_data    = '0;
        if (r_state == ST_BUSY) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (r_sel == IDX_W'(j)) begin
                    oreq_valid            = ireq_valid[j];
                    oreq_is_write         = ireq_is_write[j];
                    oreq_size             = ireq_size[j*3 +: 3];
                    oreq_addr             = ireq_addr[j*32 +: 32];
                    oreq_strobe           = ireq_strobe[j*4 +: 4];
                    oreq_data             = ireq_data[j*32 +: 32];
                    oreq_len              = ireq_len[j*4 +: 4];
                    iresp_ready[j]        = oresp_ready;
                    iresp_last[j]         = oresp_last;
                    iresp_data[j*32 +: 32] = oresp_data;
                end
            end
        end
    end

    assign busy      = (r_state == ST_BUSY);
    assign grant_idx = r_sel;

endmodule
`default_nettype wire
